// File: rtl/dsel_pkg.sv
// Shared definitions for the data-select sequencer: state codes, mux control
// encodings and default parameters.
package dsel_pkg;

  localparam int DSEL_ADDR_W = 4;
  localparam int DSEL_SETTLE = 2;

  localparam logic DSEL_CTL_DB  = 1'b0;
  localparam logic DSEL_CTL_ROM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_VALID = 2'd2,
    ST_DONE  = 2'd3
  } dsel_state_t;

  // Maps the latched operand source onto the mux control encoding.
  function automatic logic ctl_for(input logic use_rom);
    return use_rom ? DSEL_CTL_ROM : DSEL_CTL_DB;
  endfunction

endpackage

// File: rtl/dsel_seq_ctrl_if.sv
// Command and operand-handshake bundle between the top level, the sequencer
// and the data-select/ROM datapath.
interface dsel_seq_ctrl_if
  import dsel_pkg::*;
#(
  parameter int ADDR_W = DSEL_ADDR_W
);

  logic              start;
  logic              use_rom;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] len;
  logic              abort;
  logic              ctl;
  logic [ADDR_W-1:0] rom_addr;
  logic              op_valid;
  logic              op_ready;
  logic [ADDR_W-1:0] op_idx;
  logic              busy;
  logic              done;

  modport master (
    output start, use_rom, base_addr, len, abort, op_ready,
    input  ctl, rom_addr, op_valid, op_idx, busy, done
  );

  modport slave (
    input  start, use_rom, base_addr, len, abort, op_ready,
    output ctl, rom_addr, op_valid, op_idx, busy, done
  );

endinterface

// File: rtl/dsel_seq_ctrl.sv
// Sequencer for the 8-bit data-select stage: steps the mux control and ROM
// address through a run of operands and hands each settled pair downstream.
module dsel_seq_ctrl
  import dsel_pkg::*;
#(
  parameter int ADDR_W = DSEL_ADDR_W,
  parameter int SETTLE = DSEL_SETTLE
) (
  input  logic           clk,
  input  logic           rst_n,
  dsel_seq_ctrl_if.slave bus
);

  localparam int                CNT_W     = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  dsel_state_t       state_q;
  logic [CNT_W-1:0]  settle_q;
  logic [ADDR_W-1:0] last_q;
  logic              ctl_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              op_valid_q;
  logic [ADDR_W-1:0] idx_q;
  logic              busy_q;
  logic              done_q;

  // Every output is a register; ctl and rom_addr move only on start or on an
  // index advance, so the select stage always sees them stable while op_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      last_q     <= '0;
      ctl_q      <= 1'b0;
      rom_addr_q <= '0;
      op_valid_q <= 1'b0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.len != '0) begin
              ctl_q      <= ctl_for(bus.use_rom);
              rom_addr_q <= bus.base_addr;
              idx_q      <= '0;
              last_q     <= bus.len - ADDR_ONE;
              settle_q   <= SETTLE_LD;
              state_q    <= ST_SETUP;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end

        ST_SETUP: begin
          if (bus.abort) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (settle_q == CNT_ONE) begin
            op_valid_q <= 1'b1;
            state_q    <= ST_VALID;
          end else begin
            settle_q <= settle_q - CNT_ONE;
          end
        end

        // Abort outranks a same-cycle handshake: the transfer still happened
        // downstream, but the run ends here.
        ST_VALID: begin
          if (bus.abort) begin
            op_valid_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end else if (bus.op_ready) begin
            op_valid_q <= 1'b0;
            if (idx_q == last_q) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q      <= idx_q + ADDR_ONE;
              rom_addr_q <= rom_addr_q + ADDR_ONE;
              settle_q   <= SETTLE_LD;
              state_q    <= ST_SETUP;
            end
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          op_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ctl      = ctl_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.op_valid = op_valid_q;
  assign bus.op_idx   = idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_dsel_seq_ctrl.sv
// Bench for dsel_seq_ctrl with a behavioural ROM + data-select stage and a
// timestamp-based reference model compared every cycle.
module tb_dsel_seq_ctrl;

  localparam int AW     = 4;
  localparam int SETTLE = 2;

  logic clk;
  logic rst_n;
  logic cmp_en;
  int   checks;
  int   failures;

  dsel_seq_ctrl_if #(.ADDR_W(AW)) bus ();

  dsel_seq_ctrl #(.ADDR_W(AW), .SETTLE(SETTLE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Datapath stand-in: 16x8 ROM with one-cycle read, then the select register.
  logic [7:0] rom [16];
  logic [7:0] rom_q;
  logic [7:0] da;
  logic [7:0] db;
  logic [7:0] dataa_q;
  logic [7:0] datab_q;

  initial for (int i = 0; i < 16; i++) rom[i] = 8'hC0 + 8'(i);

  always @(posedge clk) begin
    rom_q   <= rom[bus.rom_addr];
    dataa_q <= da;
    datab_q <= bus.ctl ? rom_q : db;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a run owns a timestamp of its last start/advance edge;
  // the operand is valid SETTLE edges later and stays valid until taken.
  int cyc;
  int ready_at;
  int e_len;
  int e_idx;
  int e_addr;
  int e_ctl;
  bit e_busy;
  bit e_valid;
  bit e_done;
  bit hs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; ready_at = 0; e_len = 0; e_idx = 0; e_addr = 0; e_ctl = 0;
      e_busy = 1'b0; e_valid = 1'b0; e_done = 1'b0;
    end else begin
      cyc++;
      hs = e_valid && bus.op_ready;
      if (e_done) begin
        e_done = 1'b0;
        e_busy = 1'b0;
      end else if (!e_busy) begin
        if (bus.start) begin
          e_busy = 1'b1;
          if (bus.len == '0) e_done = 1'b1;
          else begin
            e_ctl    = int'(bus.use_rom);
            e_addr   = int'(bus.base_addr);
            e_len    = int'(bus.len);
            e_idx    = 0;
            ready_at = cyc + SETTLE;
          end
        end
      end else if (bus.abort) begin
        e_valid = 1'b0;
        e_done  = 1'b1;
      end else if (hs) begin
        e_valid = 1'b0;
        if (e_idx == e_len - 1) e_done = 1'b1;
        else begin
          e_idx++;
          e_addr   = (e_addr + 1) % 16;
          ready_at = cyc + SETTLE;
        end
      end else if (!e_valid && cyc == ready_at) begin
        e_valid = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      checkOutput("cmp_busy", int'(bus.busy), int'(e_busy));
      checkOutput("cmp_op_valid", int'(bus.op_valid), int'(e_valid));
      checkOutput("cmp_done", int'(bus.done), int'(e_done));
      checkOutput("cmp_ctl", int'(bus.ctl), e_ctl);
      checkOutput("cmp_rom_addr", int'(bus.rom_addr), e_addr);
      checkOutput("cmp_op_idx", int'(bus.op_idx), e_idx);
      if (e_valid) begin
        checkOutput("cmp_datab", int'(datab_q), e_ctl != 0 ? 32'hC0 + e_addr : int'(db));
        checkOutput("cmp_dataa", int'(dataa_q), int'(da));
      end
    end
  end

  int log_cyc[$];
  int log_addr[$];
  int log_idx[$];
  int log_datab[$];

  // Issues a start in the current cycle (cycle 0) and returns at cycle 1.
  task automatic applyStimulus(input logic use_rom, input logic [AW-1:0] base,
                               input logic [AW-1:0] len, input logic with_abort);
    @(negedge clk);
    bus.use_rom   = use_rom;
    bus.base_addr = base;
    bus.len       = len;
    bus.abort     = with_abort;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic runLog(input int budget, output int done_at);
    log_cyc.delete(); log_addr.delete(); log_idx.delete(); log_datab.delete();
    done_at = -1;
    for (int k = 1; k <= budget; k++) begin
      if (bus.op_valid) begin
        log_cyc.push_back(k);
        log_addr.push_back(int'(bus.rom_addr));
        log_idx.push_back(int'(bus.op_idx));
        log_datab.push_back(int'(datab_q));
      end
      if (bus.done) begin
        done_at = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic waitValid(input string name, input int budget);
    for (int k = 0; k < budget && !bus.op_valid; k++) @(negedge clk);
    checkOutput(name, int'(bus.op_valid), 1);
  endtask

  task automatic idleGap();
    repeat (3) @(negedge clk);
  endtask

  int done_at;
  int t1_cyc[3]   = '{3, 6, 9};
  int t1_datab[3] = '{32'hC2, 32'hC3, 32'hC4};

  initial begin
    checks = 0; failures = 0; cmp_en = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.use_rom = 1'b0; bus.base_addr = '0; bus.len = '0;
    bus.abort = 1'b0; bus.op_ready = 1'b0;
    da = 8'h3C; db = 8'h00;
    @(negedge clk);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_op_valid", int'(bus.op_valid), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_rom_addr", int'(bus.rom_addr), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    idleGap();

    $display("[TB] test 1: ROM run base=2 len=3");
    bus.op_ready = 1'b1;
    applyStimulus(1'b1, 4'd2, 4'd3, 1'b0);
    runLog(40, done_at);
    checkOutput("t1_done_cycle", done_at, 10);
    checkOutput("t1_n_valid", log_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < log_cyc.size()) begin
        checkOutput("t1_valid_cycle", log_cyc[i], t1_cyc[i]);
        checkOutput("t1_datab", log_datab[i], t1_datab[i]);
        checkOutput("t1_rom_addr", log_addr[i], 2 + i);
      end
    end
    idleGap();

    $display("[TB] test 2: Db run len=2 with abort alongside start");
    db = 8'h5A;
    applyStimulus(1'b0, 4'd9, 4'd2, 1'b1);
    runLog(40, done_at);
    checkOutput("t2_done_cycle", done_at, 7);
    checkOutput("t2_n_valid", log_cyc.size(), 2);
    for (int i = 0; i < 2; i++) begin
      if (i < log_cyc.size()) begin
        checkOutput("t2_datab", log_datab[i], 32'h5A);
        checkOutput("t2_op_idx", log_idx[i], i);
      end
    end
    @(negedge clk);
    checkOutput("t2_done_single", int'(bus.done), 0);
    idleGap();

    $display("[TB] test 3: backpressure on operand 1");
    applyStimulus(1'b1, 4'd5, 4'd3, 1'b0);
    waitValid("t3_op0_valid", 10);
    @(negedge clk);
    bus.op_ready = 1'b0;
    waitValid("t3_op1_valid", 10);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_hold_valid", int'(bus.op_valid), 1);
      checkOutput("t3_hold_addr", int'(bus.rom_addr), 6);
      checkOutput("t3_hold_datab", int'(datab_q), 32'hC6);
      checkOutput("t3_hold_idx", int'(bus.op_idx), 1);
      if (i == 4) bus.op_ready = 1'b1;
      @(negedge clk);
    end
    checkOutput("t3_drop_valid", int'(bus.op_valid), 0);
    checkOutput("t3_advance_idx", int'(bus.op_idx), 2);
    runLog(40, done_at);
    checkOutput("t3_done_cycle", done_at, 4);
    checkOutput("t3_last_datab", log_datab.size() > 0 ? log_datab[0] : -1, 32'hC7);
    idleGap();

    $display("[TB] test 4: len=0 and address wrap");
    applyStimulus(1'b1, 4'd7, 4'd0, 1'b0);
    runLog(20, done_at);
    checkOutput("t4_len0_done_cycle", done_at, 1);
    checkOutput("t4_len0_n_valid", log_cyc.size(), 0);
    idleGap();
    applyStimulus(1'b1, 4'd15, 4'd2, 1'b0);
    runLog(40, done_at);
    checkOutput("t4_wrap_n_valid", log_addr.size(), 2);
    checkOutput("t4_wrap_addr0", log_addr.size() > 0 ? log_addr[0] : -1, 15);
    checkOutput("t4_wrap_addr1", log_addr.size() > 1 ? log_addr[1] : -1, 0);
    checkOutput("t4_wrap_datab1", log_datab.size() > 1 ? log_datab[1] : -1, 32'hC0);
    idleGap();

    $display("[TB] test 5: abort on operand 1 of 4, stray start mid-run");
    applyStimulus(1'b1, 4'd4, 4'd4, 1'b0);
    bus.start = 1'b1; bus.use_rom = 1'b0; bus.base_addr = 4'd0; bus.len = 4'd7;
    @(negedge clk);
    bus.start = 1'b0;
    waitValid("t5_op0_valid", 10);
    @(negedge clk);
    waitValid("t5_op1_valid", 10);
    checkOutput("t5_op1_idx", int'(bus.op_idx), 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("t5_abort_valid", int'(bus.op_valid), 0);
    checkOutput("t5_abort_done", int'(bus.done), 1);
    checkOutput("t5_abort_addr", int'(bus.rom_addr), 5);
    @(negedge clk);
    checkOutput("t5_after_busy", int'(bus.busy), 0);
    idleGap();

    $display("[TB] test 6: reset mid-SETUP then fresh run");
    applyStimulus(1'b1, 4'd3, 4'd3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_busy", int'(bus.busy), 0);
    checkOutput("t6_async_ctl", int'(bus.ctl), 0);
    checkOutput("t6_async_addr", int'(bus.rom_addr), 0);
    @(negedge clk);
    checkOutput("t6_no_done", int'(bus.done), 0);
    rst_n = 1'b1;
    idleGap();
    applyStimulus(1'b1, 4'd8, 4'd2, 1'b0);
    runLog(40, done_at);
    checkOutput("t6_done_cycle", done_at, 7);
    checkOutput("t6_addr0", log_addr.size() > 0 ? log_addr[0] : -1, 8);
    checkOutput("t6_addr1", log_addr.size() > 1 ? log_addr[1] : -1, 9);
    idleGap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
